product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/acc_pkg.sv | 16 +
 rtl/acc_adder.sv | 14 +
 rtl/product_accumulator.sv | 98 +++++++++
 tb/tb_product_accumulator.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and default widths for product_accumulator
// Contents: state_t (ST_IDLE/ST_ACC/ST_DONE), default PROD_W/LEN_W/ACC_W constants.
package acc_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int LEN_W_DEF  = 8;
  // Sum of 2^LEN_W-1 terms of PROD_W bits always fits in PROD_W+LEN_W bits.
  localparam int ACC_W_DEF  = PROD_W_DEF + LEN_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/acc_adder.sv
// rtl/acc_adder.sv - combinational accumulator adder (acc + zero-extended product)
// Ports: acc [ACC_W] in, prod [PROD_W] in, sum [ACC_W] out.
module acc_adder #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum
);

  assign sum = acc + ACC_W'(prod);

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums len unsigned product words and presents the total
// Ports: clk, rst_n (async active-low); start/len command; abort cancel;
//        prod_valid/prod_ready/prod product stream in; res_valid/res_ready/res result out;
//        busy high whenever not idle.
module product_accumulator
  import acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ACC_W  = PROD_W + LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res,
  output logic              busy
);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n, sum;
  logic [LEN_W-1:0] remaining, rem_n;
  logic             beat;

  acc_adder #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) u_adder (
    .acc (acc),
    .prod(prod),
    .sum (sum)
  );

  // Ready depends only on state and abort so upstream can wait on it safely.
  assign prod_ready = (state == ST_ACC) && !abort;
  assign beat       = prod_valid && prod_ready;
  assign res        = acc;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    rem_n   = remaining;
    if (abort) begin
      state_n = ST_IDLE;
      acc_n   = '0;
      rem_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc_n = '0;
            if (len != '0) begin
              rem_n   = len;
              state_n = ST_ACC;
            end else begin
              state_n = ST_DONE;
            end
          end
        end
        ST_ACC: begin
          if (beat) begin
            acc_n = sum;
            rem_n = remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state_n = ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // res_valid and busy are flopped from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      remaining <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      remaining <= rem_n;
      res_valid <= (state_n == ST_DONE);
      busy      <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed self-checking bench for product_accumulator
module tb_product_accumulator;

  localparam int PROD_W = 64;
  localparam int LEN_W  = 8;
  localparam int ACC_W  = 72;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              abort;
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res;
  logic              busy;

  int checks = 0;
  int errors = 0;

  product_accumulator #(
    .PROD_W(PROD_W),
    .LEN_W (LEN_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .prod_valid(prod_valid),
    .prod      (prod),
    .prod_ready(prod_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [PROD_W-1:0] bp_vals [4];
    bp_vals[0] = 64'd10; bp_vals[1] = 64'd20; bp_vals[2] = 64'd30; bp_vals[3] = 64'd40;

    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    prod_valid = 1'b0; prod = '0; res_ready = 1'b0;
    #3;
    check("rst_res_valid", 72'(res_valid), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_prod_ready", 72'(prod_ready), 72'd0);
    check("rst_res", res, 72'd0);
    step();
    rst_n = 1'b1;
    step();

    // Basic sum 5+7+9
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    check("basic_busy", 72'(busy), 72'd1);
    check("basic_ready", 72'(prod_ready), 72'd1);
    prod_valid = 1'b1; prod = 64'd5; step();
    prod = 64'd7; step();
    check("basic_no_early_valid", 72'(res_valid), 72'd0);
    prod = 64'd9; step();
    prod_valid = 1'b0;
    check("basic_res_valid", 72'(res_valid), 72'd1);
    check("basic_res", res, 72'd21);
    check("basic_ready_done", 72'(prod_ready), 72'd0);
    res_ready = 1'b1; step();
    res_ready = 1'b0;
    check("basic_idle_busy", 72'(busy), 72'd0);
    check("basic_idle_valid", 72'(res_valid), 72'd0);

    // Zero length
    start = 1'b1; len = 8'd0;
    check("zero_ready_idle", 72'(prod_ready), 72'd0);
    step();
    start = 1'b0;
    check("zero_res_valid", 72'(res_valid), 72'd1);
    check("zero_res", res, 72'd0);
    check("zero_ready_done", 72'(prod_ready), 72'd0);
    res_ready = 1'b1; step();
    res_ready = 1'b0;
    check("zero_idle", 72'(busy), 72'd0);

    // Overflow bound: 255 beats of all-ones
    start = 1'b1; len = 8'd255; step();
    start = 1'b0;
    prod_valid = 1'b1; prod = '1;
    repeat (254) step();
    check("ovf_not_done", 72'(res_valid), 72'd0);
    step();
    prod_valid = 1'b0;
    check("ovf_res_valid", 72'(res_valid), 72'd1);
    check("ovf_res", res, 72'hFE_FFFF_FFFF_FFFF_FF01);
    res_ready = 1'b1; step();
    res_ready = 1'b0;

    // Backpressure: valid every other cycle, start/len poked mid-operation
    start = 1'b1; len = 8'd4; step();
    for (int i = 0; i < 8; i++) begin
      start = 1'b1; len = 8'd9;
      prod_valid = (i % 2 == 0);
      prod = bp_vals[i/2];
      step();
    end
    start = 1'b0; prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 72'(res_valid), 72'd1);
      check("bp_hold_res", res, 72'd100);
      step();
    end
    res_ready = 1'b1; step();
    res_ready = 1'b0;
    check("bp_idle_busy", 72'(busy), 72'd0);
    check("bp_idle_valid", 72'(res_valid), 72'd0);

    // Abort after 2 of 4 beats, valid high in abort cycle
    start = 1'b1; len = 8'd4; step();
    start = 1'b0;
    prod_valid = 1'b1; prod = 64'd1; step();
    prod = 64'd2; step();
    abort = 1'b1; prod = 64'd100;
    #1;
    check("abort_ready_low", 72'(prod_ready), 72'd0);
    step();
    abort = 1'b0; prod_valid = 1'b0;
    check("abort_busy", 72'(busy), 72'd0);
    check("abort_valid", 72'(res_valid), 72'd0);
    check("abort_acc", res, 72'd0);
    abort = 1'b1; start = 1'b1; len = 8'd2; step();
    abort = 1'b0;
    check("abort_wins_start", 72'(busy), 72'd0);
    start = 1'b1; len = 8'd1; step();
    start = 1'b0;
    prod_valid = 1'b1; prod = 64'd3; step();
    prod_valid = 1'b0;
    check("post_abort_valid", 72'(res_valid), 72'd1);
    check("post_abort_res", res, 72'd3);
    res_ready = 1'b1; step();
    res_ready = 1'b0;

    // Async reset mid-ACC between edges
    start = 1'b1; len = 8'd3; step();
    start = 1'b0;
    prod_valid = 1'b1; prod = 64'd8; step();
    prod_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_busy", 72'(busy), 72'd0);
    check("areset_ready", 72'(prod_ready), 72'd0);
    check("areset_valid", 72'(res_valid), 72'd0);
    check("areset_res", res, 72'd0);
    rst_n = 1'b1;
    start = 1'b1; len = 8'd1; step();
    start = 1'b0;
    check("areset_restart_busy", 72'(busy), 72'd1);
    check("areset_restart_ready", 72'(prod_ready), 72'd1);
    prod_valid = 1'b1; prod = 64'd6; step();
    prod_valid = 1'b0;
    check("areset_restart_valid", 72'(res_valid), 72'd1);
    check("areset_restart_res", res, 72'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
